i2c_cmd_sequencer: RTL and testbench

I2C_CMD_SEQUENCER -- requirements
Module: i2c_cmd_sequencer

---
 rtl/i2c_seq_pkg.sv | 83 ++++++++
 rtl/apb_single_master.sv | 45 ++++
 rtl/i2c_cmd_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_i2c_cmd_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_seq_pkg.sv
// Shared constants, state/op encodings and the per-step operation table for i2c_cmd_sequencer.
package i2c_seq_pkg;

  localparam logic [8:0] REG_CTRL = 9'h000;
  localparam logic [8:0] REG_STAT = 9'h004;
  localparam logic [8:0] REG_DATA = 9'h008;

  localparam int CTRL_CR2  = 7;
  localparam int CTRL_ENS1 = 6;
  localparam int CTRL_STA  = 5;
  localparam int CTRL_STO  = 4;
  localparam int CTRL_SI   = 3;
  localparam int CTRL_AA   = 2;

  localparam logic [7:0] STAT_START      = 8'h08;
  localparam logic [7:0] STAT_RSTART     = 8'h10;
  localparam logic [7:0] STAT_SLA_W_ACK  = 8'h18;
  localparam logic [7:0] STAT_DATA_W_ACK = 8'h28;
  localparam logic [7:0] STAT_SLA_R_ACK  = 8'h40;
  localparam logic [7:0] STAT_DATA_R_NAK = 8'h58;

  typedef enum logic [2:0] {
    INIT, IDLE, APB_XFER, WAIT_INT, CHK_STAT, STOP, DONE
  } seq_state_e;

  typedef enum logic [3:0] {
    OP_STA, OP_CLR, OP_DEV_W, OP_DEV_R, OP_REG, OP_WDATA, OP_RD_DATA, OP_END
  } op_e;

  typedef struct packed {
    op_e        op;
    logic       wait_int;
    logic [7:0] exp_stat;
  } seq_op_t;

  // SI and AA are always written as 0: every CTRL write also acknowledges SI
  function automatic logic [7:0] ctrl_word(input logic [2:0] cr, input logic sta,
                                           input logic sto);
    logic [7:0] w;
    w            = '0;
    w[CTRL_CR2]  = cr[2];
    w[CTRL_ENS1] = 1'b1;
    w[CTRL_STA]  = sta;
    w[CTRL_STO]  = sto;
    w[CTRL_SI]   = 1'b0;
    w[CTRL_AA]   = 1'b0;
    w[1:0]       = cr[1:0];
    return w;
  endfunction

  function automatic seq_op_t seq_op(input logic rd, input logic [3:0] step);
    seq_op_t s;
    s = '{OP_END, 1'b0, 8'h00};
    if (!rd) begin
      case (step)
        4'd0:    s = '{OP_STA,   1'b1, STAT_START};
        4'd1:    s = '{OP_DEV_W, 1'b0, 8'h00};
        4'd2:    s = '{OP_CLR,   1'b1, STAT_SLA_W_ACK};
        4'd3:    s = '{OP_REG,   1'b0, 8'h00};
        4'd4:    s = '{OP_CLR,   1'b1, STAT_DATA_W_ACK};
        4'd5:    s = '{OP_WDATA, 1'b0, 8'h00};
        4'd6:    s = '{OP_CLR,   1'b1, STAT_DATA_W_ACK};
        default: s = '{OP_END,   1'b0, 8'h00};
      endcase
    end else begin
      case (step)
        4'd0:    s = '{OP_STA,     1'b1, STAT_START};
        4'd1:    s = '{OP_DEV_W,   1'b0, 8'h00};
        4'd2:    s = '{OP_CLR,     1'b1, STAT_SLA_W_ACK};
        4'd3:    s = '{OP_REG,     1'b0, 8'h00};
        4'd4:    s = '{OP_CLR,     1'b1, STAT_DATA_W_ACK};
        4'd5:    s = '{OP_STA,     1'b1, STAT_RSTART};
        4'd6:    s = '{OP_DEV_R,   1'b0, 8'h00};
        4'd7:    s = '{OP_CLR,     1'b1, STAT_SLA_R_ACK};
        4'd8:    s = '{OP_CLR,     1'b1, STAT_DATA_R_NAK};
        4'd9:    s = '{OP_RD_DATA, 1'b0, 8'h00};
        default: s = '{OP_END,     1'b0, 8'h00};
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/apb_single_master.sv
// One APB read or write per start pulse; done marks the access cycle, where PRDATA is valid.
module apb_single_master (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       start,
  input  logic       write,
  input  logic [8:0] addr,
  input  logic [7:0] wdata,
  output logic       done,
  output logic [7:0] rdata,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [8:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA
);

  // start is only honoured while idle, so a held start cannot stretch a transfer
  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else if (!PSEL) begin
      if (start) begin
        PSEL   <= 1'b1;
        PWRITE <= write;
        PADDR  <= addr;
        PWDATA <= wdata;
      end
    end else if (!PENABLE) begin
      PENABLE <= 1'b1;
    end else begin
      PSEL    <= 1'b0;
      PENABLE <= 1'b0;
    end
  end

  assign done  = PSEL & PENABLE;
  assign rdata = PRDATA;

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Drives a CoreI2C through single-register write/read transactions over APB.
// Optional I2C_SEQ_TIMEOUT_EN adds a 16-bit watchdog on each interrupt wait.
//
// state    | meaning
// INIT     | one CTRL write enabling the core after reset
// IDLE     | cmd_ready high, waiting for a command
// APB_XFER | issue the core operation selected by step
// WAIT_INT | wait for the core's SI interrupt
// CHK_STAT | read STAT and compare with the expected code
// STOP     | write CTRL with STO set
// DONE     | one-cycle response pulse
module i2c_cmd_sequencer #(
  parameter logic [2:0] CR_SEL         = 3'b000,
  parameter int         TIMEOUT_CYCLES = 65535
) (
  input  logic       PCLK,
  input  logic       PRESETN,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rd,
  input  logic [6:0] cmd_dev,
  input  logic [7:0] cmd_reg,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       PSEL,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [8:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic [7:0] PRDATA,
  input  logic       i2c_int
);
  import i2c_seq_pkg::*;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must fit the 16-bit wait counter");
  end

  seq_state_e state_q, state_d;
  logic [3:0] step_q, step_d;
  logic       err_q, err_d;
  logic [7:0] rdata_q, rdata_d;
  logic       capture;
  logic       rd_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;
  logic       apb_start, apb_write, apb_done;
  logic [8:0] apb_addr;
  logic [7:0] apb_wdata, apb_rdata;
  logic       tmo_hit;
  seq_op_t    cur;

  assign cur = seq_op(rd_q, step_q);

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES);
  logic [15:0] tmo_cnt;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN)                tmo_cnt <= TMO_LOAD;
    else if (state_q != WAIT_INT) tmo_cnt <= TMO_LOAD;
    else if (tmo_cnt != 16'd0)   tmo_cnt <= tmo_cnt - 16'd1;
  end

  assign tmo_hit = (state_q == WAIT_INT) && (tmo_cnt == 16'd0);
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    err_d     = err_q;
    rdata_d   = rdata_q;
    capture   = 1'b0;
    apb_start = 1'b0;
    apb_write = 1'b1;
    apb_addr  = REG_CTRL;
    apb_wdata = ctrl_word(CR_SEL, 1'b0, 1'b0);
    case (state_q)
      INIT: begin
        apb_start = !PSEL;
        if (apb_done) state_d = IDLE;
      end
      IDLE: begin
        if (cmd_valid) begin
          capture = 1'b1;
          step_d  = 4'd0;
          err_d   = 1'b0;
          state_d = APB_XFER;
        end
      end
      APB_XFER: begin
        case (cur.op)
          OP_STA:     apb_wdata = ctrl_word(CR_SEL, 1'b1, 1'b0);
          OP_CLR:     apb_wdata = ctrl_word(CR_SEL, 1'b0, 1'b0);
          OP_DEV_W:   begin apb_addr = REG_DATA; apb_wdata = {dev_q, 1'b0}; end
          OP_DEV_R:   begin apb_addr = REG_DATA; apb_wdata = {dev_q, 1'b1}; end
          OP_REG:     begin apb_addr = REG_DATA; apb_wdata = reg_q; end
          OP_WDATA:   begin apb_addr = REG_DATA; apb_wdata = wdata_q; end
          OP_RD_DATA: begin apb_addr = REG_DATA; apb_write = 1'b0; end
          default:    ;
        endcase
        if (cur.op == OP_END) begin
          state_d = STOP;
        end else begin
          apb_start = !PSEL;
          if (apb_done) begin
            if (cur.op == OP_RD_DATA) rdata_d = apb_rdata;
            if (cur.wait_int) state_d = WAIT_INT;
            else              step_d  = step_q + 4'd1;
          end
        end
      end
      WAIT_INT: begin
        if (i2c_int) begin
          state_d = CHK_STAT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = STOP;
        end
      end
      CHK_STAT: begin
        apb_write = 1'b0;
        apb_addr  = REG_STAT;
        apb_start = !PSEL;
        if (apb_done) begin
          if (apb_rdata != cur.exp_stat) begin
            err_d   = 1'b1;
            state_d = STOP;
          end else begin
            step_d  = step_q + 4'd1;
            state_d = APB_XFER;
          end
        end
      end
      STOP: begin
        apb_wdata = ctrl_word(CR_SEL, 1'b0, 1'b1);
        apb_start = !PSEL;
        if (apb_done) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q <= INIT;
      step_q  <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      rd_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      rd_q    <= cmd_rd;
      dev_q   <= cmd_dev;
      reg_q   <= cmd_reg;
      wdata_q <= cmd_wdata;
    end
  end

  apb_single_master u_apb (
    .PCLK    (PCLK),
    .PRESETN (PRESETN),
    .start   (apb_start),
    .write   (apb_write),
    .addr    (apb_addr),
    .wdata   (apb_wdata),
    .done    (apb_done),
    .rdata   (apb_rdata),
    .PSEL    (PSEL),
    .PENABLE (PENABLE),
    .PWRITE  (PWRITE),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PRDATA  (PRDATA)
  );

  assign cmd_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == DONE);
  assign rsp_err   = err_q;
  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Self-checking bench for i2c_cmd_sequencer with a behavioural CoreI2C slave model.
module tb_i2c_cmd_sequencer;

  logic       PCLK = 1'b0;
  logic       PRESETN;
  logic       cmd_valid, cmd_ready, cmd_rd;
  logic [6:0] cmd_dev;
  logic [7:0] cmd_reg, cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       PSEL, PENABLE, PWRITE;
  logic [8:0] PADDR;
  logic [7:0] PWDATA, PRDATA;
  logic       i2c_int;

  i2c_cmd_sequencer #(.CR_SEL(3'b000), .TIMEOUT_CYCLES(100)) dut (
    .PCLK(PCLK), .PRESETN(PRESETN),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rd(cmd_rd),
    .cmd_dev(cmd_dev), .cmd_reg(cmd_reg), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .i2c_int(i2c_int)
  );

  always #5 PCLK = ~PCLK;

  typedef struct {
    logic       rd;
    logic [6:0] dev;
    logic [7:0] rg;
    logic [7:0] wd;
    logic       nack;
    logic [7:0] slave_rd;
    logic       exp_err;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
  } rsp_t;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_data[$];
  rsp_t       exp_rsp[$];

  // slave model state
  logic [7:0] m_stat = 8'h00, m_pend = 8'h00, m_last = 8'h00, m_rd_byte = 8'h00;
  logic       m_active = 1'b0, m_nack = 1'b0, int_en = 1'b1;
  logic       expect_init = 1'b1, stop_seen = 1'b0, prev_rv = 1'b0;
  int         int_cnt = 0;

  initial i2c_int = 1'b0;

  assign PRDATA = (PADDR == 9'h004) ? m_stat : (PADDR == 9'h008) ? m_rd_byte : 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    total++;
    bad++;
    $display("FAIL %s: %s", name, what);
  endtask

  always @(negedge PCLK) begin
    if (!PRESETN) begin
      i2c_int     = 1'b0;
      int_cnt     = 0;
      m_active    = 1'b0;
      m_stat      = 8'h00;
      stop_seen   = 1'b0;
      expect_init = 1'b1;
      prev_rv     = 1'b0;
      exp_data.delete();
      exp_rsp.delete();
    end else begin
      if (int_cnt > 0) begin
        int_cnt--;
        if (int_cnt == 0 && int_en) begin
          m_stat  = m_pend;
          i2c_int = 1'b1;
        end
      end
      if (PSEL && PENABLE && PWRITE && PADDR == 9'h000) begin
        if (expect_init) begin
          chk("init_ctrl", {24'd0, PWDATA}, 32'h40);
          expect_init = 1'b0;
        end else begin
          i2c_int = 1'b0;
          int_cnt = 0;
          if (PWDATA[4]) begin
            chk("stop_ctrl", {24'd0, PWDATA}, 32'h50);
            stop_seen = 1'b1;
            m_active  = 1'b0;
          end else if (PWDATA[5]) begin
            chk("start_ctrl", {24'd0, PWDATA}, 32'h60);
            m_pend   = m_active ? 8'h10 : 8'h08;
            m_active = 1'b1;
            int_cnt  = 3;
          end else begin
            chk("clear_si_ctrl", {24'd0, PWDATA}, 32'h40);
            case (m_stat)
              8'h08:        m_pend = m_nack ? 8'h20 : (m_last[0] ? 8'h40 : 8'h18);
              8'h10:        m_pend = m_last[0] ? 8'h40 : 8'h18;
              8'h18, 8'h28: m_pend = 8'h28;
              8'h40:        m_pend = 8'h58;
              default:      m_pend = 8'hF8;
            endcase
            int_cnt = 3;
          end
        end
      end else if (PSEL && PENABLE && PWRITE && PADDR == 9'h008) begin
        m_last = PWDATA;
        if (exp_data.size() == 0) fail_now("unexpected_data", $sformatf("got 0x%0h required none", PWDATA));
        else chk("data_byte", {24'd0, PWDATA}, {24'd0, exp_data.pop_front()});
      end
      if (rsp_valid) begin
        if (prev_rv) fail_now("rsp_pulse_width", "rsp_valid high two cycles, required one");
        if (exp_rsp.size() == 0) begin
          fail_now("unexpected_rsp", $sformatf("got err=%0b rdata=0x%0h required none", rsp_err, rsp_rdata));
        end else begin
          rsp_t e;
          e = exp_rsp.pop_front();
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
          chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rdata});
          chk("stop_before_rsp", {31'd0, stop_seen}, 32'd1);
          chk("data_all_seen", exp_data.size(), 32'd0);
          stop_seen = 1'b0;
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 2000) begin
      @(negedge PCLK);
      n++;
    end
    if (!cmd_ready) fail_now("ready_timeout", "cmd_ready low after 2000 cycles, required high");
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_rsp.size() != 0 && n < 3000) begin
      @(negedge PCLK);
      n++;
    end
    if (exp_rsp.size() != 0) fail_now("rsp_timeout", "no rsp_valid within 3000 cycles, required one");
    @(negedge PCLK);
  endtask

  task automatic drive_cmd(input vec_t v);
    wait_ready();
    cmd_rd    = v.rd;
    cmd_dev   = v.dev;
    cmd_reg   = v.rg;
    cmd_wdata = v.wd;
    cmd_valid = 1'b1;
    @(posedge PCLK);
    #1;
    // keep a different command asserted while busy; it must not be taken
    cmd_dev = ~v.dev;
    cmd_reg = ~v.rg;
    repeat (10) @(negedge PCLK);
    chk("busy_no_ready", {31'd0, cmd_ready}, 32'd0);
    cmd_valid = 1'b0;
  endtask

  task automatic push_expect(input vec_t v);
    m_nack    = v.nack;
    m_rd_byte = v.slave_rd;
    exp_data.push_back({v.dev, 1'b0});
    if (!v.nack) begin
      exp_data.push_back(v.rg);
      exp_data.push_back(v.rd ? {v.dev, 1'b1} : v.wd);
    end
    exp_rsp.push_back('{err: v.exp_err, rdata: v.exp_rdata});
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b0, 7'h21, 8'h12, 8'h80, 1'b0, 8'h00, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 7'h21, 8'h0A, 8'h00, 1'b0, 8'h76, 1'b0, 8'h76};
    vecs[2] = '{1'b0, 7'h21, 8'h12, 8'h80, 1'b1, 8'h00, 1'b1, 8'h76};
    vecs[3] = '{1'b0, 7'h55, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b0, 8'h76};
    vecs[4] = '{1'b1, 7'h7F, 8'h00, 8'h00, 1'b0, 8'hA5, 1'b0, 8'hA5};
    vecs[5] = '{1'b1, 7'h10, 8'h33, 8'h00, 1'b1, 8'h3C, 1'b1, 8'hA5};
    vecs[6] = '{1'b0, 7'h7E, 8'h01, 8'hFF, 1'b0, 8'h00, 1'b0, 8'hA5};

    PRESETN   = 1'b0;
    cmd_valid = 1'b0;
    cmd_rd    = 1'b0;
    cmd_dev   = '0;
    cmd_reg   = '0;
    cmd_wdata = '0;
    repeat (3) @(negedge PCLK);
    chk("reset_apb", {29'd0, PSEL, PENABLE, PWRITE}, 32'd0);
    chk("reset_addr_data", {15'd0, PADDR, PWDATA}, 32'd0);
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    chk("reset_rsp", {22'd0, rsp_valid, rsp_err, rsp_rdata}, 32'd0);
    PRESETN = 1'b1;
    wait_ready();
    chk("init_done_before_ready", {31'd0, expect_init}, 32'd0);

    foreach (vecs[i]) begin
      push_expect(vecs[i]);
      drive_cmd(vecs[i]);
      wait_rsp();
    end

    // reset while the register byte is on the bus
    begin
      vec_t v;
      int n = 0;
      v = '{1'b0, 7'h33, 8'h44, 8'h99, 1'b0, 8'h00, 1'b0, 8'hA5};
      push_expect(v);
      drive_cmd(v);
      while (!(PSEL && !PENABLE && PADDR == 9'h008 && PWDATA == 8'h44) && n < 2000) begin
        @(negedge PCLK);
        n++;
      end
      if (n >= 2000) fail_now("reg_byte_timeout", "register byte never reached the bus");
      PRESETN = 1'b0;
      #1;
      chk("midreset_apb_idle", {30'd0, PSEL, PENABLE}, 32'd0);
      chk("midreset_no_rsp", {30'd0, rsp_valid, cmd_ready}, 32'd0);
      chk("midreset_rdata", {24'd0, rsp_rdata}, 32'd0);
      repeat (3) @(negedge PCLK);
      PRESETN = 1'b1;
      wait_ready();
      chk("init_rerun", {31'd0, expect_init}, 32'd0);
      chk("no_rsp_after_reset", exp_rsp.size(), 32'd0);
    end

    // interrupt never arrives
    begin
      vec_t v;
      v = '{1'b0, 7'h21, 8'h12, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00};
      int_en = 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
      exp_rsp.push_back('{err: 1'b1, rdata: 8'h00});
      drive_cmd(v);
      wait_rsp();
      chk("timeout_back_to_idle", {31'd0, cmd_ready}, 32'd1);
`else
      drive_cmd(v);
      repeat (400) @(negedge PCLK);
      chk("stuck_in_wait", {30'd0, cmd_ready, PSEL}, 32'd0);
      chk("no_stop_while_waiting", {31'd0, stop_seen}, 32'd0);
`endif
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
